// File: rtl/fft64_twiddle_sched.sv
// Twiddle scheduler for one stage of a radix-2 DIF 64-point FFT: tags each
// sample with constant-bank select, conjugate and quadrant controls.
module fft64_twiddle_sched #(
    parameter int W   = 10,
    parameter int NPT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          stage,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic [3:0]          tw_sel,
    output logic                tw_conj,
    output logic [1:0]          tw_quad,
    output logic                out_last,
    output logic                busy,
    output logic                done
);
    localparam int IDX_W = $clog2(NPT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Exponent k from sample index and stage, folded onto W64^0..W64^8 by
    // conjugate symmetry; k[5:4] selects the extra (-j)^q rotation.
    function automatic logic [6:0] tw_decode(input logic [5:0] n, input logic [2:0] s);
        logic [6:0] len;
        logic [5:0] half, j, k;
        logic [3:0] r, sel;
        logic       conj;
        len  = 7'd64 >> s;
        half = len[6:1];
        j    = n & 6'(len - 7'd1);
        k    = (j < half) ? 6'd0 : 6'((j - half) << s);
        r    = k[3:0];
        if (r == 4'd0) begin
            sel  = 4'd0;
            conj = 1'b0;
        end else if (r <= 4'd8) begin
            sel  = r;
            conj = 1'b0;
        end else begin
            sel  = 4'(5'd16 - {1'b0, r});
            conj = 1'b1;
        end
        return {sel, conj, k[5:4]};
    endfunction

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [2:0]             stage_q;
    logic                   en, accept;

    logic                   vld_p0, last_p0;
    logic signed [W-1:0]    re_p0, im_p0;
    logic [IDX_W-1:0]       n_p0;
    logic [2:0]             s_p0;

    logic                   vld_p1, last_p1, conj_p1, done_q;
    logic signed [W-1:0]    re_p1, im_p1;
    logic [3:0]             sel_p1;
    logic [1:0]             quad_p1;

    assign en     = !vld_p1 || out_ready;
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: if (start && stage <= 3'd5) state_d = RUN;
            RUN: begin
                in_ready = en;
                if (in_valid && en && idx_q == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == RUN) begin
                stage_q <= stage;
                idx_q   <= '0;
            end else if (accept) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Stage p0: accepted sample with its index, stage and last flag.
    // The stage travels with the sample so a new frame can start while draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            re_p0   <= '0;
            im_p0   <= '0;
            n_p0    <= '0;
            s_p0    <= '0;
            last_p0 <= 1'b0;
        end else if (en) begin
            vld_p0 <= accept;
            if (accept) begin
                re_p0   <= in_re;
                im_p0   <= in_im;
                n_p0    <= idx_q;
                s_p0    <= stage_q;
                last_p0 <= (idx_q == LAST_IDX);
            end
        end
    end

    // Stage p1: decoded twiddle controls, aligned with the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            re_p1   <= '0;
            im_p1   <= '0;
            sel_p1  <= '0;
            conj_p1 <= 1'b0;
            quad_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (en) begin
            vld_p1                      <= vld_p0;
            re_p1                       <= re_p0;
            im_p1                       <= im_p0;
            {sel_p1, conj_p1, quad_p1}  <= tw_decode(6'(n_p0), s_p0);
            last_p1                     <= last_p0 && vld_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= vld_p1 && out_ready && last_p1;
    end

    assign out_valid = vld_p1;
    assign out_re    = re_p1;
    assign out_im    = im_p1;
    assign tw_sel    = sel_p1;
    assign tw_conj   = conj_p1;
    assign tw_quad   = quad_p1;
    assign out_last  = last_p1;
    assign done      = done_q;
    assign busy      = (state_q == RUN) || vld_p0 || vld_p1;
endmodule

// File: tb/tb_fft64_twiddle_sched.sv
// Bench for fft64_twiddle_sched: randomized frames against a queue-based
// reference model with the twiddle exponent computed arithmetically.
module tb_fft64_twiddle_sched;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, out_valid, out_ready;
    logic tw_conj, out_last, busy, done;
    logic [2:0]   stage;
    logic [W-1:0] in_re, in_im, out_re, out_im;
    logic [3:0]   tw_sel;
    logic [1:0]   tw_quad;

    always #5 clk = ~clk;

    fft64_twiddle_sched #(.W(W), .NPT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .tw_sel(tw_sel), .tw_conj(tw_conj), .tw_quad(tw_quad),
        .out_last(out_last), .busy(busy), .done(done)
    );

    typedef struct {
        int           n;
        int           s;
        logic [W-1:0] re;
        logic [W-1:0] im;
        int           cyc;
    } item_t;

    item_t q[$];
    int checks = 0, errors = 0, cyc = 0, n_m = 0, s_m = 0;
    bit running = 1'b0, exp_done = 1'b0, ff = 1'b0;

    int sp_s[8]   = '{0, 0, 0, 0, 0, 1, 1, 1};
    int sp_n[8]   = '{10, 33, 41, 48, 63, 20, 31, 40};
    int sp_sel[8] = '{0, 1, 7, 0, 1, 8, 2, 0};
    int sp_cj[8]  = '{0, 0, 1, 0, 1, 0, 1, 0};
    int sp_qd[8]  = '{0, 0, 0, 1, 1, 0, 1, 0};

    function automatic int exp_k(input int n, input int s);
        int len, h, j;
        len = 64 >> s;
        h   = len / 2;
        j   = n % len;
        return (j < h) ? 0 : ((j - h) << s) % 64;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_re"}, out_re, 0);
        chk({tag, "_im"}, out_im, 0);
        chk({tag, "_sel"}, tw_sel, 0);
        chk({tag, "_conj"}, tw_conj, 0);
        chk({tag, "_quad"}, tw_quad, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovalid"}, out_valid, 0);
        chk({tag, "_iready"}, in_ready, 0);
    endtask

    // One clock cycle: inputs already driven; check, update model, advance.
    task automatic cycle();
        item_t e, it;
        bit exp_ir, was_running, next_done;
        int k, r, sel, cj;
        #1;
        exp_ir = running && (!out_valid || out_ready);
        chk("in_ready", in_ready, exp_ir);
        chk("busy", busy, running || (q.size() != 0));
        chk("done", done, exp_done);
        next_done = 1'b0;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e   = q.pop_front();
                k   = exp_k(e.n, e.s);
                r   = k % 16;
                sel = (r == 0) ? 0 : (r <= 8) ? r : 16 - r;
                cj  = (r > 8) ? 1 : 0;
                chk("out_re", out_re, e.re);
                chk("out_im", out_im, e.im);
                chk("tw_sel", tw_sel, sel);
                chk("tw_conj", tw_conj, cj);
                chk("tw_quad", tw_quad, k / 16);
                chk("out_last", out_last, (e.n == 63) ? 1 : 0);
                for (int i = 0; i < 8; i++)
                    if (e.s == sp_s[i] && e.n == sp_n[i]) begin
                        chk("spot_sel", tw_sel, sp_sel[i]);
                        chk("spot_conj", tw_conj, sp_cj[i]);
                        chk("spot_quad", tw_quad, sp_qd[i]);
                    end
                if (ff) chk("latency", cyc - e.cyc, 2);
                next_done = (e.n == 63);
            end
        end
        was_running = running;
        if (in_valid && exp_ir) begin
            it.n = n_m; it.s = s_m; it.re = in_re; it.im = in_im; it.cyc = cyc;
            q.push_back(it);
            n_m++;
            if (n_m == 64) running = 1'b0;
        end
        if (!was_running && start && stage <= 3'd5) begin
            running = 1'b1;
            n_m     = 0;
            s_m     = int'(stage);
        end
        exp_done = next_done;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_frames(input int s0, input int s1, input bit bp, input int nfr, input bit fixed);
        int started = 0, guard = 0;
        while ((started < nfr || running || q.size() != 0) && guard < 3000) begin
            start    = (!running && started < nfr);
            stage    = 3'((started == 0) ? s0 : s1);
            if (start) started++;
            in_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_re    = fixed ? 10'h200 : W'($urandom);
            in_im    = fixed ? 10'h1FF : W'($urandom);
            if (bp) out_ready = (guard >= 20 && guard < 25) ? 1'b0 : 1'($urandom_range(0, 1));
            else    out_ready = 1'b1;
            cycle();
            guard++;
        end
        if (guard >= 3000) chk("timeout", 0, 1);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) cycle();
    endtask

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0; stage = 3'd0; in_valid = 1'b0;
        in_re = '0; in_im = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) cycle();

        // Idle: invalid stage and stray in_valid must do nothing.
        start = 1'b1; stage = 3'd6; in_valid = 1'b1; in_re = 10'h155;
        repeat (4) cycle();
        start = 1'b0;
        repeat (3) cycle();
        in_valid = 1'b0;
        cycle();

        ff = 1'b1;
        run_frames(0, 0, 1'b0, 1, 1'b0);
        run_frames(1, 1, 1'b0, 1, 1'b0);
        run_frames(5, 5, 1'b0, 1, 1'b1);
        ff = 1'b0;
        run_frames($urandom_range(0, 5), 0, 1'b1, 1, 1'b0);
        ff = 1'b1;
        run_frames(2, 4, 1'b0, 2, 1'b0);
        ff = 1'b0;
        run_frames(3, 1, 1'b1, 2, 1'b0);

        // Reset mid-frame at n=20.
        ff = 1'b1;
        start = 1'b1; stage = 3'd0; out_ready = 1'b1;
        cycle();
        start = 1'b0; in_valid = 1'b1;
        guard = 0;
        while (n_m < 20 && guard < 200) begin
            in_re = W'($urandom); in_im = W'($urandom);
            cycle();
            guard++;
        end
        if (guard >= 200) chk("timeout_mid", 0, 1);
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        q.delete(); running = 1'b0; n_m = 0; exp_done = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle();
        run_frames(0, 0, 1'b0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft64_twiddle_sched.md
Name: fft64_twiddle_sched

Overview:
- Per-stage twiddle scheduler for the radix-2 DIF 64-point FFT.
- Accepts one stage's 64-sample stream and computes the twiddle exponent k of each sample.
- Reduces k to a fixed-constant select plus symmetry controls (conjugate, quadrant rotation) for the W64^m constant-multiplier bank.
- Forwards the sample with its controls, time-aligned, over a valid/ready stream.
- Sits between the stage butterfly and the twiddle multiplier bank.

Parameters:
- W, 10, data width of each real/imag component (two's complement).
- NPT, 64, points per frame; only 64 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  frame start pulse; sampled only in IDLE
- stage  in  3  DIF stage 0..5; latched on accepted start
- in_valid  in  1  input sample valid
- in_ready  out  1  input sample accepted when in_valid && in_ready
- in_re, in_im  in  W  input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream ready
- out_re, out_im  out  W  sample, unmodified
- tw_sel  out  4  0 = bypass (W^0); 1..8 = multiplier constant W64^m
- tw_conj  out  1  use conj(W^m): negate imag before and after the constant multiply
- tw_quad  out  2  extra (-j)^q rotation (the W^16 unit), applied after tw_sel
- out_last  out  1  marks the 64th sample of the frame
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when the last sample leaves the output

Behaviour:
- Reset (async, rst=1): FSM=IDLE, index=0, stage_q=0.
  - Pipeline valid bits = 0.
  - All outputs 0: out_re/out_im/tw_*/out_last/done/busy/out_valid/in_ready.
- FSM IDLE:
  - in_ready=0.
  - start=1 with stage<=5 → latch stage_q, index=0, go to RUN.
  - start with stage>5 is ignored; stay in IDLE.
- FSM RUN:
  - in_ready = en, where en = !out_valid || out_ready (global pipeline stall).
  - Each accepted sample increments index (6-bit).
  - Acceptance at index 63 → IDLE.
  - start is ignored while in RUN.
- Exponent, for sample index n with s = stage_q:
  - L = 64>>s, h = L/2, j = n mod L.
  - j < h → k = 0.
  - j >= h → k = ((j-h) << s) mod 64; k is always < 32.
- Reduction:
  - q = k[5:4], r = k[3:0].
  - r=0 → tw_sel=0, tw_conj=0.
  - 1<=r<=8 → tw_sel=r, tw_conj=0.
  - 9<=r<=15 → tw_sel=16-r, tw_conj=1.
  - tw_quad=q.
- Pipeline:
  - Two register stages. Stage 1 holds sample, n and last flag. Stage 2 holds decoded controls.
  - Latency is exactly 2 cycles from acceptance to out_valid when out_ready stays high.
  - When en=0 both stages hold; data and controls never separate or duplicate.
- out_last=1 with the sample accepted at index 63.
- done pulses in the cycle after the out_last sample handshakes (out_valid && out_ready && out_last).
- busy = (FSM==RUN) || any pipeline stage valid.
- Back-to-back frames: a new start is honored in IDLE even while the previous frame drains the pipeline. The drain continues unaffected.
- in_valid while in IDLE: no acceptance; the data is ignored.
- rst asserted mid-frame: immediate return to reset state; partial frame discarded; no done pulse.

Test Plan:
- Stage 0, feed n=0..63 with out_ready=1. Required outputs:
  - n=10 → sel0/conj0/quad0.
  - n=33 → sel1/conj0/quad0.
  - n=41 → sel7/conj1/quad0.
  - n=48 → sel0/quad1.
  - n=63 → sel1/conj1/quad1, out_last=1.
  - done pulses one cycle later. Latency is 2 cycles on every sample.
- Stage 1: n=20 → k=8 → sel8/conj0/quad0. n=31 → k=30 → sel2/conj1/quad1. n=40 → sel0.
- Stage 5: all 64 samples → sel0/conj0/quad0. Data is passed bit-exact: in_re=10'h200, in_im=10'h1FF out unchanged.
- Backpressure: out_ready toggled pseudo-randomly, including held low for 5 cycles. Required:
  - in_ready=0 while stalled.
  - Exactly 64 outputs, in order, with controls matching n.
  - No drops or duplicates.
- start with stage=6 in IDLE → no transition. in_valid held high in IDLE → in_ready=0, nothing emitted.
- rst pulse at n=20 of a frame:
  - Next cycle all outputs are 0, busy=0, no done.
  - A new start with stage 0 then produces a correct full frame from n=0.
